// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the VGA control path: speed and palette codes, the
//   pin positions of each control field inside ui_in, the frame-latched
//   control bundle, and a helper that slices those fields out of the
//   debounced pin vector.
// -----------------------------------------------------------------------------
package vga_pkg;

  typedef enum logic [1:0] {
    SPD_NORMAL = 2'd0,
    SPD_FAST   = 2'd1,
    SPD_SLOW   = 2'd2,
    SPD_PAUSE  = 2'd3
  } speed_e;

  typedef enum logic [1:0] {
    PAL_CLASSIC = 2'd0,
    PAL_CYBER   = 2'd1,
    PAL_FOREST  = 2'd2,
    PAL_MONO    = 2'd3
  } palette_e;

  // Positions of the control fields inside the conditioned pin vector.
  localparam int SPEED_LSB    = 0;
  localparam int SPEED_W      = 2;
  localparam int PALETTE_LSB  = 2;
  localparam int PALETTE_W    = 2;
  localparam int SCANLINE_BIT = 4;
  localparam int CTRL_PINS    = SCANLINE_BIT + 1;

  typedef struct packed {
    logic     scanline_off;
    palette_e palette;
    speed_e   speed;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_pins(input logic [CTRL_PINS-1:0] pins);
    ctrl_t c;
    c.speed        = speed_e'(pins[SPEED_LSB +: SPEED_W]);
    c.palette      = palette_e'(pins[PALETTE_LSB +: PALETTE_W]);
    c.scanline_off = pins[SCANLINE_BIT];
    return c;
  endfunction

endpackage : vga_pkg

// File: rtl/vga_debounce_bit.sv
// -----------------------------------------------------------------------------
// vga_debounce_bit
//   Conditions one asynchronous pin: 2-flop synchroniser, stability counter,
//   accepted-level flop and a registered rising-edge pulse.
//
//   Ports
//     clk       in  pixel clock
//     reset     in  asynchronous, active-high reset
//     raw_i     in  asynchronous pin level
//     stable_o  out debounced level
//     rise_o    out one-cycle pulse, the cycle after stable_o goes 0->1
//
//   A new level is accepted only after it has been seen at the synchroniser
//   output for DEBOUNCE_CYCLES consecutive cycles; any shorter excursion just
//   returns the counter to 0.
// -----------------------------------------------------------------------------
module vga_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;
  logic             stable_dly_q;
  logic             rise_q;
  logic             rise_d;

  // NOTE: combinational blocks assign a default to every output first, so no
  // path can leave a signal unassigned and infer a latch.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // stable_dly_q holds last cycle's level, so the pulse lands one cycle
  // after the accepted level rises and never on a fall.
  assign rise_d = stable_q & ~stable_dly_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values; this is what keeps s1 -> s2 a true 2-stage
  // chain rather than collapsing into one flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      cnt_q        <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      // Synchroniser: nothing may sit between s1 and s2.
      s1_q         <= raw_i;
      s2_q         <= s1_q;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      rise_q       <= rise_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule : vga_debounce_bit

// File: rtl/vga_input_conditioner.sv
// -----------------------------------------------------------------------------
// vga_input_conditioner
//   Upstream stage of the VGA pixel/animation logic. Debounces every ui_in
//   pin, produces rising-edge pulses, and latches the speed / palette /
//   scanline fields only at frame start so a change never tears mid-frame.
//
//   Ports
//     clk                in  pixel clock
//     reset              in  asynchronous, active-high reset
//     raw_in[N_IN]       in  asynchronous pin levels
//     frame_start        in  1-cycle pulse on the vsync rising edge
//     stable_out[N_IN]   out debounced levels
//     rise_pulse[N_IN]   out 1-cycle pulse after stable_out[i] rises
//     ctrl_speed[2]      out frame-latched stable_out[1:0]
//     ctrl_palette[2]    out frame-latched stable_out[3:2]
//     ctrl_scanline_off  out frame-latched stable_out[4]
//     ctrl_pause         out pause latch
//
//   Build option
//     VGA_PAUSE_TOGGLE_EN  when defined, pin TOGGLE_BIT is a momentary pause
//                          button: presses are collected during a frame and
//                          toggle ctrl_pause once at the next frame_start.
//                          When undefined, ctrl_pause is tied to 0.
// -----------------------------------------------------------------------------
module vga_input_conditioner
  import vga_pkg::*;
#(
  parameter int N_IN            = 8,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int CNT_W           = 16,
  parameter int TOGGLE_BIT      = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] raw_in,
  input  logic            frame_start,
  output logic [N_IN-1:0] stable_out,
  output logic [N_IN-1:0] rise_pulse,
  output logic [1:0]      ctrl_speed,
  output logic [1:0]      ctrl_palette,
  output logic            ctrl_scanline_off,
  output logic            ctrl_pause
);

  // Elaboration-time guard against parameter sets the logic cannot honour.
  if (N_IN < CTRL_PINS || TOGGLE_BIT >= N_IN || DEBOUNCE_CYCLES < 2 ||
      (2 ** CNT_W) < DEBOUNCE_CYCLES) begin : g_bad_params
    $error("vga_input_conditioner: illegal parameter combination");
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_pin
    vga_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (raw_in[i]),
      .stable_o (stable_out[i]),
      .rise_o   (rise_pulse[i])
    );
  end

  // Frame latch: samples the registered stable_out, so a level that flips on
  // the same edge as frame_start is captured as its old value and the new one
  // is only picked up at the following frame_start.
  ctrl_t ctrl_q;
  ctrl_t ctrl_d;

  always_comb begin
    ctrl_d = ctrl_q;
    if (frame_start) begin
      ctrl_d = ctrl_from_pins(stable_out[CTRL_PINS-1:0]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ctrl_speed        = ctrl_q.speed;
  assign ctrl_palette      = ctrl_q.palette;
  assign ctrl_scanline_off = ctrl_q.scanline_off;

`ifdef VGA_PAUSE_TOGGLE_EN
  // pending_q remembers "at least one press this frame"; extra presses merge.
  // A press arriving on the frame_start edge itself reloads pending so it
  // counts toward the next frame rather than being lost.
  logic pending_q;
  logic pending_d;
  logic pause_q;
  logic pause_d;

  always_comb begin
    pending_d = pending_q | rise_pulse[TOGGLE_BIT];
    pause_d   = pause_q;
    if (frame_start) begin
      pause_d   = pause_q ^ pending_q;
      pending_d = rise_pulse[TOGGLE_BIT];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      pause_q   <= pause_d;
    end
  end

  assign ctrl_pause = pause_q;
`else
  assign ctrl_pause = 1'b0;
`endif

endmodule : vga_input_conditioner

// File: tb/tb_vga_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_vga_input_conditioner
//   Self-checking bench for vga_input_conditioner with DEBOUNCE_CYCLES=4,
//   CNT_W=3. A driver applies inputs on the falling edge and pushes the
//   reference model's expected outputs for the coming rising edge into a
//   queue; a monitor pops and compares shortly after every rising edge.
//   The model works from the raw-sample history: a pin's level is accepted
//   once the synchronised value has differed from the accepted level for a
//   full window of DEBOUNCE_CYCLES consecutive edges since the last change.
// -----------------------------------------------------------------------------
module tb_vga_input_conditioner;

  localparam int N      = 8;
  localparam int D      = 4;
  localparam int CW     = 3;
  localparam int TB_BIT = 7;
  localparam int MAXE   = 16384;

`ifdef VGA_PAUSE_TOGGLE_EN
  localparam logic EXP_PAUSE_AFTER_TWO = 1'b1;
`else
  localparam logic EXP_PAUSE_AFTER_TWO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         frame_start = 1'b0;
  logic [N-1:0] raw_in = '0;
  logic [N-1:0] stable_out;
  logic [N-1:0] rise_pulse;
  logic [1:0]   ctrl_speed;
  logic [1:0]   ctrl_palette;
  logic         ctrl_scanline_off;
  logic         ctrl_pause;
  logic [21:0]  outs;

  assign outs = {stable_out, rise_pulse, ctrl_speed, ctrl_palette,
                 ctrl_scanline_off, ctrl_pause};

  vga_input_conditioner #(
    .N_IN            (N),
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW),
    .TOGGLE_BIT      (TB_BIT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .raw_in            (raw_in),
    .frame_start       (frame_start),
    .stable_out        (stable_out),
    .rise_pulse        (rise_pulse),
    .ctrl_speed        (ctrl_speed),
    .ctrl_palette      (ctrl_palette),
    .ctrl_scanline_off (ctrl_scanline_off),
    .ctrl_pause        (ctrl_pause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [N-1:0] hist [MAXE];   // raw level sampled at each edge (0 while in reset)
  logic [N-1:0] sh   [MAXE];   // accepted level after each edge
  logic [N-1:0] rh   [MAXE];   // rise pulse after each edge
  int           last_change [N];
  int           k = 0;
  logic [1:0]   m_speed = '0;
  logic [1:0]   m_pal = '0;
  logic         m_scan = 1'b0;
  logic         m_pause = 1'b0;
`ifdef VGA_PAUSE_TOGGLE_EN
  int           presses = 0;
`endif
  logic [21:0]  sb [$];

  task automatic model_step(input logic [N-1:0] r, input logic fs, input logic rs);
    k++;
    if (k >= MAXE) begin
      $display("FAIL model_capacity: got edge %0d, expected below %0d", k, MAXE);
      $fatal(1, "model history exhausted");
    end
    if (rs) begin
      hist[k] = '0;
      sh[k]   = '0;
      rh[k]   = '0;
      for (int i = 0; i < N; i++) last_change[i] = k;
      m_speed = '0;
      m_pal   = '0;
      m_scan  = 1'b0;
      m_pause = 1'b0;
`ifdef VGA_PAUSE_TOGGLE_EN
      presses = 0;
`endif
    end else begin
      for (int i = 0; i < N; i++) begin
        logic accept;
        accept = (k - last_change[i]) >= D;
        // Synchronised value seen at edge j is the raw level sampled two edges earlier.
        for (int j = k - D + 1; j <= k && accept; j++) begin
          if (hist[j-2][i] == sh[k-1][i]) accept = 1'b0;
        end
        sh[k][i] = accept ? ~sh[k-1][i] : sh[k-1][i];
        if (accept) last_change[i] = k;
      end
      rh[k] = sh[k-1] & ~sh[k-2];
      if (fs) begin
        m_speed = sh[k-1][1:0];
        m_pal   = sh[k-1][3:2];
        m_scan  = sh[k-1][4];
      end
`ifdef VGA_PAUSE_TOGGLE_EN
      if (fs) begin
        if (presses > 0) m_pause = ~m_pause;
        presses = int'(rh[k-1][TB_BIT]);
      end else begin
        presses += int'(rh[k-1][TB_BIT]);
      end
`endif
      hist[k] = r;
    end
    sb.push_back({sh[k], rh[k], m_speed, m_pal, m_scan, m_pause});
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    logic [21:0] e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("scoreboard", 32'(outs), 32'(e));
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic step(input logic [N-1:0] r, input logic fs, input logic rs);
    logic was_rst;
    @(negedge clk);
    was_rst     = reset;
    raw_in      = r;
    frame_start = fs;
    reset       = rs;
    model_step(r, fs, rs);
    if (rs && !was_rst) begin
      #1;
      check("reset_immediate", 32'(outs), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [N-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b0, 1'b0);
  endtask

  task automatic press(input logic [N-1:0] base);
    run(base | 8'h80, D + 3);
    run(base, D + 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_e;
    int rise_e;
    int rise_n;
    logic seen_s, seen_r, seen_p;
    logic [N-1:0] r;
    logic [N-1:0] m;
    logic fs, rs;

    for (int i = 0; i < MAXE; i++) begin
      hist[i] = '0;
      sh[i]   = '0;
      rh[i]   = '0;
    end
    for (int i = 0; i < N; i++) last_change[i] = 0;

    // Reset and idle.
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);
    run(8'h00, 2);
    check("reset_state", 32'(outs), 32'd0);

    // 1. Latency of a clean 0->1 on pin 0 and the single rise pulse.
    first_e = 0; rise_e = 0; rise_n = 0;
    for (int e = 1; e <= 10; e++) begin
      step(8'h01, 1'b0, 1'b0);
      if (stable_out[0] && first_e == 0) first_e = e;
      if (rise_pulse[0]) begin rise_n++; rise_e = e; end
    end
    check("t1_stable_edge", 32'(first_e), 32'd6);
    check("t1_rise_edge", 32'(rise_e), 32'd7);
    check("t1_rise_count", 32'(rise_n), 32'd1);

    // 2. Three-cycle glitch on pin 2 is rejected.
    seen_s = 1'b0; seen_r = 1'b0; seen_p = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step((e <= 3) ? 8'h05 : 8'h01, e == 8, 1'b0);
      if (stable_out[2]) seen_s = 1'b1;
      if (rise_pulse[2]) seen_r = 1'b1;
      if (ctrl_palette != 2'b00) seen_p = 1'b1;
    end
    check("t2_stable_glitch", 32'(seen_s), 32'd0);
    check("t2_rise_glitch", 32'(seen_r), 32'd0);
    check("t2_palette_glitch", 32'(seen_p), 32'd0);
    check("t2_speed_latched", 32'(ctrl_speed), 32'd1);

    // 3. Palette changes only at frame_start; coincident flip is deferred.
    run(8'h09, 8);
    check("t3_stable_field", 32'(stable_out[3:2]), 32'd2);
    check("t3_palette_hold", 32'(ctrl_palette), 32'd0);
    step(8'h09, 1'b1, 1'b0);
    check("t3_palette_load", 32'(ctrl_palette), 32'd2);
    run(8'h01, 8);
    step(8'h01, 1'b1, 1'b0);
    check("t3_palette_clear", 32'(ctrl_palette), 32'd0);
    for (int e = 1; e <= 6; e++) step(8'h09, e == 6, 1'b0);
    check("t3_coincident_stable", 32'(stable_out[3:2]), 32'd2);
    check("t3_coincident_palette", 32'(ctrl_palette), 32'd0);
    run(8'h09, 3);
    step(8'h09, 1'b1, 1'b0);
    check("t3_next_frame_palette", 32'(ctrl_palette), 32'd2);

    // 4. Pause button: two presses in one frame give one toggle.
    step(8'h09, 1'b1, 1'b0);
    press(8'h09);
    press(8'h09);
    check("t4_pause_midframe", 32'(ctrl_pause), 32'd0);
    step(8'h09, 1'b1, 1'b0);
    check("t4_pause_two_presses", 32'(ctrl_pause), 32'(EXP_PAUSE_AFTER_TWO));
    press(8'h09);
    step(8'h09, 1'b1, 1'b0);
    check("t4_pause_third_press", 32'(ctrl_pause), 32'd0);

    // 5. Reset mid-count discards progress; full latency needed afterwards.
    run(8'h03, 4);
    step(8'h03, 1'b0, 1'b1);
    step(8'h03, 1'b0, 1'b1);
    check("t5_in_reset", 32'(outs), 32'd0);
    first_e = 0;
    for (int e = 1; e <= 8; e++) begin
      step(8'h03, 1'b0, 1'b0);
      if (stable_out[1] && first_e == 0) first_e = e;
    end
    check("t5_relock_edge", 32'(first_e), 32'd6);

    // 6. Random toggling, frame_start every 800 cycles (some back-to-back),
    //    and one mid-run reset.
    r = 8'h03;
    for (int c = 0; c < 10000; c++) begin
      m = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(15) == 0) m[b] = 1'b1;
      r  = r ^ m;
      fs = (c % 800 == 0) || ((c % 800 == 1) && (c < 1700));
      rs = (c == 5000) || (c == 5001);
      step(r, fs, rs);
    end

    run(r, 3);
    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_vga_input_conditioner
